// File: rtl/uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_deserializer
// Brief    : Oversampled UART receiver. Frames are a 0 start bit, DATA_BITS data
//            bits sent MSB first, and a 1 stop bit. Each bit is sampled at its centre.
// Revision : 1.0 - initial release
// ============================================================================
module uart_rx_deserializer #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_en,
    input  logic                 serial_in,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 data_valid,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int c_CNT_W = $clog2(OVERSAMPLE);
    localparam int c_BIT_W = $clog2(DATA_BITS + 1);

    localparam logic [c_CNT_W-1:0] c_HALF_LAST = c_CNT_W'(OVERSAMPLE / 2 - 1);
    localparam logic [c_CNT_W-1:0] c_FULL_LAST = c_CNT_W'(OVERSAMPLE - 1);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT  = c_BIT_W'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t               r_state;
    logic [1:0]           r_sync;
    logic [c_CNT_W-1:0]   r_sample_cnt;
    logic [c_BIT_W-1:0]   r_bit_cnt;
    logic [DATA_BITS-1:0] r_shreg;
    logic                 w_rx_s;

    assign w_rx_s = r_sync[1];
    assign busy   = (r_state != S_IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_sync       <= 2'b11;
            r_sample_cnt <= '0;
            r_bit_cnt    <= '0;
            r_shreg      <= '0;
            data_out     <= '0;
            data_valid   <= 1'b0;
            frame_err    <= 1'b0;
        end else begin
            r_sync     <= {r_sync[0], serial_in};
            data_valid <= 1'b0;
            frame_err  <= 1'b0;

            if (sample_en) begin
                case (r_state)
                    S_IDLE: begin
                        if (!w_rx_s) begin
                            r_state      <= S_START;
                            r_sample_cnt <= '0;
                        end
                    end

                    // A start bit that is gone by its centre is treated as line noise.
                    S_START: begin
                        if (r_sample_cnt == c_HALF_LAST) begin
                            r_sample_cnt <= '0;
                            if (w_rx_s) begin
                                r_state <= S_IDLE;
                            end else begin
                                r_state   <= S_DATA;
                                r_bit_cnt <= '0;
                            end
                        end else begin
                            r_sample_cnt <= r_sample_cnt + 1'b1;
                        end
                    end

                    S_DATA: begin
                        if (r_sample_cnt == c_FULL_LAST) begin
                            r_shreg      <= {r_shreg[DATA_BITS-2:0], w_rx_s};
                            r_bit_cnt    <= r_bit_cnt + 1'b1;
                            r_sample_cnt <= '0;
                            if (r_bit_cnt == c_LAST_BIT) begin
                                r_state <= S_STOP;
                            end
                        end else begin
                            r_sample_cnt <= r_sample_cnt + 1'b1;
                        end
                    end

                    // Leaving at the stop-bit centre leaves half a bit to catch a back-to-back start edge.
                    S_STOP: begin
                        if (r_sample_cnt == c_FULL_LAST) begin
                            r_sample_cnt <= '0;
                            if (w_rx_s) begin
                                data_out   <= r_shreg;
                                data_valid <= 1'b1;
                                r_state    <= S_IDLE;
                            end else begin
                                frame_err <= 1'b1;
                                r_state   <= S_BREAK;
                            end
                        end else begin
                            r_sample_cnt <= r_sample_cnt + 1'b1;
                        end
                    end

                    S_BREAK: begin
                        if (w_rx_s) begin
                            r_state <= S_IDLE;
                        end
                    end

                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_deserializer.sv
`default_nettype none
// ============================================================================
// Module   : tb_uart_rx_deserializer
// Brief    : Random-stimulus scoreboard bench. A frame-level line model queues the
//            expected events, and a monitor checks every output pulse against that queue.
// Revision : 1.0 - initial release
// ============================================================================
module tb_uart_rx_deserializer;

    localparam int OS = 16;

    typedef struct {
        logic       err;
        logic [7:0] data;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       sample_en = 1'b0;
    logic       serial_in = 1'b1;
    logic [7:0] data_out;
    logic       data_valid;
    logic       frame_err;
    logic       busy;

    int         n_checks = 0;
    int         n_errors = 0;
    int         div = 1;
    int         div_ph = 0;
    logic [7:0] last_good = 8'h00;
    logic       prev_pulse = 1'b0;
    exp_t       sb[$];

    uart_rx_deserializer #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .sample_en  (sample_en),
        .serial_in  (serial_in),
        .data_out   (data_out),
        .data_valid (data_valid),
        .frame_err  (frame_err),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every output pulse consumes one queued expectation.
    always @(negedge clk) begin
        if (!reset && (data_valid || frame_err)) begin
            exp_t e;
            check("pulse_exclusive", 32'(data_valid & frame_err), 32'd0);
            check("pulse_width", 32'(prev_pulse), 32'd0);
            if (sb.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_pulse: got valid=%0b err=%0b expected none at %0t",
                         data_valid, frame_err, $time);
            end else begin
                e = sb.pop_front();
                check("event_kind", 32'(frame_err), 32'(e.err));
                if (e.err) begin
                    check("data_hold_on_err", 32'(data_out), 32'(last_good));
                end else begin
                    check("rx_data", 32'(data_out), 32'(e.data));
                    last_good = e.data;
                end
            end
        end
        prev_pulse = data_valid | frame_err;
    end

    task automatic step();
        @(negedge clk);
        div_ph = (div_ph + 1) % div;
        sample_en = (div_ph == 0);
    endtask

    task automatic ticks(input int n);
        int k = 0;
        while (k < n) begin
            step();
            if (sample_en) k++;
        end
    endtask

    // Line-level transmitter; the expected event is queued before the stop-bit centre.
    task automatic send_frame(input logic [7:0] b, input logic stop_ok, input int low_hold);
        exp_t e;
        serial_in = 1'b0;
        ticks(OS);
        for (int i = 7; i >= 0; i--) begin
            serial_in = b[i];
            ticks(OS);
            if (i == 4) check("busy_in_frame", 32'(busy), 32'd1);
        end
        e.err  = ~stop_ok;
        e.data = b;
        sb.push_back(e);
        serial_in = stop_ok;
        if (stop_ok) begin
            ticks(OS);
        end else begin
            ticks(low_hold);
            check("busy_in_break", 32'(busy), 32'd1);
            serial_in = 1'b1;
            ticks(OS);
        end
    endtask

    initial begin
        logic [7:0] b;
        repeat (3) step();
        check("reset_data_out", 32'(data_out), 32'd0);
        check("reset_valid", 32'(data_valid), 32'd0);
        check("reset_err", 32'(frame_err), 32'd0);
        check("reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        ticks(20);

        send_frame(8'hA5, 1'b1, 0);
        ticks(4);
        check("idle_after_a5", 32'(busy), 32'd0);

        // Start glitch shorter than half a bit.
        serial_in = 1'b0;
        ticks(4);
        check("glitch_busy", 32'(busy), 32'd1);
        serial_in = 1'b1;
        ticks(12);
        check("glitch_rejected", 32'(busy), 32'd0);

        send_frame(8'h3C, 1'b0, 40);
        check("data_kept_after_err", 32'(data_out), 32'hA5);
        send_frame(8'h81, 1'b1, 0);

        send_frame(8'h00, 1'b1, 0);
        send_frame(8'hFF, 1'b1, 0);
        ticks(8);

        // Reset in the middle of data bit 4.
        serial_in = 1'b0;
        ticks(OS);
        b = 8'h5A;
        for (int i = 7; i >= 4; i--) begin
            serial_in = b[i];
            ticks((i == 4) ? OS / 2 : OS);
        end
        reset = 1'b1;
        step();
        step();
        check("midreset_data_out", 32'(data_out), 32'd0);
        check("midreset_busy", 32'(busy), 32'd0);
        check("midreset_valid", 32'(data_valid), 32'd0);
        last_good = 8'h00;
        reset = 1'b0;
        serial_in = 1'b1;
        ticks(OS * 2);
        check("postreset_idle", 32'(busy), 32'd0);
        send_frame(8'h5A, 1'b1, 0);

        for (int n = 0; n < 30; n++) begin
            send_frame(8'($urandom_range(0, 255)), ($urandom_range(0, 7) != 0), OS + 8);
            ticks($urandom_range(0, 10));
        end

        div = 3;
        div_ph = 0;
        send_frame(8'h01, 1'b1, 0);
        for (int n = 0; n < 40; n++) begin
            send_frame(8'($urandom_range(0, 255)), 1'b1, 0);
        end
        send_frame(8'hFF, 1'b1, 0);

        for (int w = 0; w < 500 && sb.size() != 0; w++) step();
        check("scoreboard_drained", 32'(sb.size()), 32'd0);
        check("final_idle", 32'(busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
